// File: rtl/cof_control_seq.sv
// cof_control_seq: registered carry-out/overflow controller for NCH precision lanes.
//
// Sits between the lane adders and the precision-control FSM. An overflow cycle (cof) is
// a valid cycle where some unmasked lane carries out of bit 32 while not every lane is
// shift-ready. While a cof is pending the block holds ovf_irq until ack. It also keeps a
// sticky record of the lanes that carried, and a saturating count of overflow cycles.
//
// Optional feature: define COF_LANE_MASK_EN to add the lane_mask input. The mask is
// captured when en rises, and masked lanes never count as hits.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous, active-high reset
//   en        in   1      monitor enable; 0 forces IDLE
//   valid_in  in   1      lane flags valid this cycle
//   carry32   in   NCH    per-lane carry out of bit 32
//   sr_rdy    in   NCH    per-lane shift-ready flag
//   ack       in   1      clears ovf_irq and lane_hit
//   clr_cnt   in   1      clears ovf_cnt (wins over increment)
//   lane_mask in   NCH    lane mask (COF_LANE_MASK_EN only)
//   Cout      out  1      registered overflow/carry-out
//   ovf_irq   out  1      overflow pending, held until ack
//   lane_hit  out  NCH    sticky lanes that carried during pending overflows
//   ovf_cnt   out  CNT_W  saturating count of overflow cycles
module cof_control_seq #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             valid_in,
   input  logic [NCH-1:0]   carry32,
   input  logic [NCH-1:0]   sr_rdy,
   input  logic             ack,
   input  logic             clr_cnt,
`ifdef COF_LANE_MASK_EN
   input  logic [NCH-1:0]   lane_mask,
`endif
   output logic             Cout,
   output logic             ovf_irq,
   output logic [NCH-1:0]   lane_hit,
   output logic [CNT_W-1:0] ovf_cnt
);

   typedef enum logic [1:0] {StIdle, StRun, StFlag} state_e;

   state_e           state_q, state_d;
   logic             cout_q, cout_d;
   logic [NCH-1:0]   hit_q, hit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NCH-1:0]   mask;
   logic [NCH-1:0]   hit;
   logic             cof;
   logic             inc;

`ifdef COF_LANE_MASK_EN
   logic             en_q;
   logic [NCH-1:0]   mask_q;

   // Mask is sampled only when monitoring is switched on.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q   <= 1'b0;
         mask_q <= '0;
      end else begin
         en_q <= en;
         if (en && !en_q) mask_q <= lane_mask;
      end
   end

   assign mask = mask_q;
`else
   assign mask = '0;
`endif

   assign hit = carry32 & ~mask;
   // All lanes shift-ready means they realign, so a carry is not an overflow.
   assign cof = valid_in & ~(&sr_rdy) & (|hit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cout_q  <= 1'b0;
         hit_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cout_q  <= cout_d;
         hit_q   <= hit_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cout_d  = 1'b0;
      hit_d   = hit_q;
      inc     = 1'b0;
      if (!en) begin
         state_d = StIdle;
         hit_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (valid_in) state_d = StRun;
            end
            StRun: begin
               cout_d = cof;
               if (cof) begin
                  state_d = StFlag;
                  inc     = 1'b1;
                  hit_d   = hit;
               end
            end
            StFlag: begin
               cout_d = cof;
               inc    = cof;
               if (ack) begin
                  // Ack drops the old record; a same-cycle overflow starts a fresh one.
                  hit_d = cof ? hit : '0;
                  if (!cof) state_d = StRun;
               end else if (cof) begin
                  hit_d = hit_q | hit;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign Cout     = cout_q;
   assign ovf_irq  = (state_q == StFlag);
   assign lane_hit = hit_q;
   assign ovf_cnt  = cnt_q;

endmodule
